mem_arbiter: RTL and testbench

- Shares the single-ported memory bus between the instruction-fetch port (I) and the load/store port (D) of the pipelined core.
- Produces the ihit/dhit completion pulses consumed by the hazard unit.
- Enforces D-first priority with forced I/D alternation under contention, so neither port starves.
- Includes a per-transaction timeout that converts a hung memory into a flagged completion.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory bus arbiter for I-fetch and load/store ports
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              iren,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   input  logic              dren,
   input  logic              dwen,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DBUSY = 2'd1,
      IBUSY = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             at_limit;
   logic             done;
   logic             tout;
   logic             d_req;
   logic             grant_d;
   logic             grant_i;

   // Completion qualifiers: a BUSY cycle ends on ram_ready or when the wait budget runs out.
   always_comb begin
      busy     = (state != IDLE);
      d_req    = dren | dwen;
      at_limit = (cnt == CNT_W'(TIMEOUT - 1));
      done     = busy & (ram_ready | at_limit);
      tout     = busy & ~ram_ready & at_limit;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and grant decisions; D wins from IDLE, but I always gets a look after a D hit.
   always_comb begin
      state_next = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      ihit       = 1'b0;
      dhit       = 1'b0;
      case (state)
         IDLE: begin
            if (!halt) begin
               if (d_req) begin
                  grant_d = 1'b1;
               end else if (iren) begin
                  grant_i = 1'b1;
               end
            end
         end
         DBUSY: begin
            if (done) begin
               dhit = 1'b1;
               if (iren && !halt) begin
                  grant_i = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         IBUSY: begin
            if (done) begin
               ihit = 1'b1;
               // iaddr seen here is already the next fetch address
               if (d_req && !halt) begin
                  grant_d = 1'b1;
               end else if (iren && !halt) begin
                  grant_i = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (grant_d) begin
         state_next = DBUSY;
      end else if (grant_i) begin
         state_next = IBUSY;
      end
   end

   // Return data: only real memory data on a ready completion; a timed-out access reads as 0.
   always_comb begin
      iload   = '0;
      dload   = '0;
      bus_err = tout;
      if (ihit && !tout) begin
         iload = ram_load;
      end
      if (dhit && !tout && ram_ren) begin
         dload = ram_load;
      end
   end

   // Wait counter: restarts on every grant, counts stalled BUSY cycles, parks at 0 in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (grant_d || grant_i || state_next == IDLE) begin
         cnt <= '0;
      end else if (busy && !ram_ready) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Memory bus registers: loaded at grant, held through the access, strobes dropped in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_ren   <= 1'b0;
         ram_wen   <= 1'b0;
         ram_addr  <= '0;
         ram_store <= '0;
      end else if (grant_d) begin
         // simultaneous dren/dwen is resolved as a write
         ram_ren   <= dren & ~dwen;
         ram_wen   <= dwen;
         ram_addr  <= daddr;
         ram_store <= dstore;
      end else if (grant_i) begin
         ram_ren   <= 1'b1;
         ram_wen   <= 1'b0;
         ram_addr  <= iaddr;
      end else if (state_next == IDLE) begin
         ram_ren   <= 1'b0;
         ram_wen   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam logic [31:0] MASK = 32'hA500_0000;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        iren;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        dren;
   logic        dwen;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dhit;
   logic [31:0] dload;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_store;
   logic [31:0] ram_load;
   logic        ram_ready;
   logic        bus_err;

   logic        auto_mode;
   logic        rready_drv;
   logic [31:0] rload_drv;

   int n_pass;
   int n_total;

   typedef struct {
      string       nm;
      logic [4:0]  ctl;   // rst, halt, iren, dren, dwen
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic        rready;
      logic [31:0] rload;
      logic [4:0]  eflg;  // ihit, dhit, bus_err, ram_ren, ram_wen
      logic [31:0] eiload;
      logic [31:0] edload;
      logic [31:0] eaddr;
      logic [31:0] estore;
   } vec_t;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
   } hit_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   hit_t sb[$];

   mem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(4),
      .CNT_W  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .halt     (halt),
      .iren     (iren),
      .iaddr    (iaddr),
      .ihit     (ihit),
      .iload    (iload),
      .dren     (dren),
      .dwen     (dwen),
      .daddr    (daddr),
      .dstore   (dstore),
      .dhit     (dhit),
      .dload    (dload),
      .ram_ren  (ram_ren),
      .ram_wen  (ram_wen),
      .ram_addr (ram_addr),
      .ram_store(ram_store),
      .ram_load (ram_load),
      .ram_ready(ram_ready),
      .bus_err  (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory side: table-driven values, or a zero-wait memory whose data is a function of the address.
   always_comb begin
      ram_ready = rready_drv;
      ram_load  = rload_drv;
      if (auto_mode) begin
         ram_ready = ram_ren | ram_wen;
         ram_load  = ram_addr ^ MASK;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [4:0] ctl, input logic [31:0] ia,
                      input logic [31:0] da, input logic [31:0] ds, input logic rr,
                      input logic [31:0] rl, input logic [4:0] ef, input logic [31:0] eil,
                      input logic [31:0] edl, input logic [31:0] ea, input logic [31:0] es);
      vec_t v;
      v.nm = nm; v.ctl = ctl; v.iaddr = ia; v.daddr = da; v.dstore = ds;
      v.rready = rr; v.rload = rl; v.eflg = ef; v.eiload = eil; v.edload = edl;
      v.eaddr = ea; v.estore = es;
      tbl.push_back(v);
   endtask

   initial begin
      vec_t v;
      vec_t e;
      hit_t h;
      int   nhits;
      logic seen_i;

      n_pass = 0; n_total = 0;
      auto_mode = 1'b0; rready_drv = 1'b0; rload_drv = '0;
      rst = 1'b1; halt = 1'b0; iren = 1'b0; dren = 1'b0; dwen = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;

      //   name                ctl       iaddr    daddr    dstore        rdy rload         eflg      eiload        edload        eaddr    estore
      add("reset",             5'b10000, 0,       0,       0,            0, 0,            5'b00000, 0,            0,            0,       0);
      add("idle_ready_nohit",  5'b00100, 'h100,   0,       0,            1, 'h55,         5'b00000, 0,            0,            0,       0);
      add("i_wait1",           5'b00100, 'h100,   0,       0,            0, 0,            5'b00010, 0,            0,            'h100,   0);
      add("i_wait2",           5'b00100, 'h100,   0,       0,            0, 0,            5'b00010, 0,            0,            'h100,   0);
      add("i_hit",             5'b00100, 'h104,   0,       0,            1, 'h1111AAAA,   5'b10010, 'h1111AAAA,   0,            'h100,   0);
      add("i_regrant",         5'b00100, 'h104,   0,       0,            0, 0,            5'b00010, 0,            0,            'h104,   0);
      add("i_hit_then_d",      5'b00101, 'h104,   'h2000,  'hCAFEF00D,   1, 'h2222,       5'b10010, 'h2222,       0,            'h104,   0);
      add("d_wr_hit",          5'b00101, 'h108,   'h2000,  'hCAFEF00D,   1, 'h3333,       5'b01001, 0,            0,            'h2000,  'hCAFEF00D);
      add("i_after_d",         5'b00101, 'h108,   'h2004,  'h12345678,   1, 'h4444,       5'b10010, 'h4444,       0,            'h108,   'hCAFEF00D);
      add("d_wr2_hit",         5'b00001, 0,       'h2004,  'h12345678,   1, 'h5555,       5'b01001, 0,            0,            'h2004,  'h12345678);
      add("idle_after_d",      5'b00000, 0,       0,       0,            1, 'h6666,       5'b00000, 0,            0,            'h2004,  'h12345678);
      add("idle_both_req",     5'b00101, 'h200,   'h2000,  'hCAFEF00D,   0, 0,            5'b00000, 0,            0,            'h2004,  'h12345678);
      add("d_granted_first",   5'b00101, 'h200,   'h2000,  'hCAFEF00D,   0, 0,            5'b00001, 0,            0,            'h2000,  'hCAFEF00D);
      add("d_first_hit",       5'b00101, 'h200,   'h2000,  'hCAFEF00D,   1, 'hDEADBEEF,   5'b01001, 0,            0,            'h2000,  'hCAFEF00D);
      add("i_second_hit",      5'b00000, 'h200,   0,       0,            1, 'h0BADC0DE,   5'b10010, 'h0BADC0DE,   0,            'h200,   'hCAFEF00D);
      add("idle_d_rd_req",     5'b00010, 0,       'h3000,  0,            0, 0,            5'b00000, 0,            0,            'h200,   'hCAFEF00D);
      add("halt_in_dbusy",     5'b01110, 'h300,   'h3000,  0,            0, 0,            5'b00010, 0,            0,            'h3000,  0);
      add("halt_d_hit",        5'b01110, 'h300,   'h3000,  0,            1, 'h5A5A5A5A,   5'b01010, 0,            'h5A5A5A5A,   'h3000,  0);
      add("halt_idle1",        5'b01100, 'h300,   0,       0,            1, 'h77,         5'b00000, 0,            0,            'h3000,  0);
      add("halt_idle2",        5'b01100, 'h300,   0,       0,            1, 'h77,         5'b00000, 0,            0,            'h3000,  0);
      add("unhalt",            5'b00100, 'h300,   0,       0,            0, 0,            5'b00000, 0,            0,            'h3000,  0);
      add("i_busy_pre_rst",    5'b00100, 'h300,   0,       0,            0, 0,            5'b00010, 0,            0,            'h300,   0);
      add("rst_in_ibusy",      5'b10100, 'h300,   0,       0,            0, 0,            5'b00010, 0,            0,            'h300,   0);
      add("after_rst",         5'b00000, 0,       0,       0,            1, 'h77,         5'b00000, 0,            0,            0,       0);
      add("idle_rd_and_wr",    5'b00011, 0,       'h4000,  'hA5A5,       0, 0,            5'b00000, 0,            0,            0,       0);
      add("rdwr_as_write",     5'b00011, 0,       'h4000,  'hA5A5,       1, 'h99,         5'b01001, 0,            0,            'h4000,  'hA5A5);
      add("idle3",             5'b00000, 0,       0,       0,            0, 0,            5'b00000, 0,            0,            'h4000,  'hA5A5);
      add("idle_d_req_to",     5'b00010, 0,       'h5000,  0,            0, 0,            5'b00000, 0,            0,            'h4000,  'hA5A5);
      for (int k = 0; k < 3; k++)
         add("d_stall",        5'b00110, 'h600,   'h5000,  0,            0, 0,            5'b00010, 0,            0,            'h5000,  0);
      add("d_timeout",         5'b00110, 'h600,   'h5000,  0,            0, 'hFFFF,       5'b01110, 0,            0,            'h5000,  0);
      for (int k = 0; k < 3; k++)
         add("i_stall",        5'b00100, 'h600,   0,       0,            0, 0,            5'b00010, 0,            0,            'h600,   0);
      add("i_ready_at_limit",  5'b00000, 'h600,   0,       0,            1, 'h6060,       5'b10010, 'h6060,       0,            'h600,   0);
      add("idle4",             5'b00000, 0,       0,       0,            0, 0,            5'b00000, 0,            0,            'h600,   0);
      add("idle_d_req_rdy",    5'b00010, 0,       'h7000,  0,            0, 0,            5'b00000, 0,            0,            'h600,   0);
      for (int k = 0; k < 3; k++)
         add("d_stall2",       5'b00010, 0,       'h7000,  0,            0, 0,            5'b00010, 0,            0,            'h7000,  0);
      add("d_ready_at_limit",  5'b00010, 0,       'h7000,  0,            1, 'h7777,       5'b01010, 0,            'h7777,       'h7000,  0);
      add("idle5",             5'b00000, 0,       0,       0,            0, 0,            5'b00000, 0,            0,            'h7000,  0);

      repeat (2) @(posedge clk);

      // Table phase: drive one vector per cycle, queue its expectation, compare at the falling edge.
      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         v = tbl[i];
         {rst, halt, iren, dren, dwen} = v.ctl;
         iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore;
         rready_drv = v.rready; rload_drv = v.rload;
         exp_q.push_back(v);
         @(negedge clk);
         e = exp_q.pop_front();
         chk({e.nm, ".ihit"},      32'(ihit),      32'(e.eflg[4]));
         chk({e.nm, ".dhit"},      32'(dhit),      32'(e.eflg[3]));
         chk({e.nm, ".bus_err"},   32'(bus_err),   32'(e.eflg[2]));
         chk({e.nm, ".ram_ren"},   32'(ram_ren),   32'(e.eflg[1]));
         chk({e.nm, ".ram_wen"},   32'(ram_wen),   32'(e.eflg[0]));
         chk({e.nm, ".ram_addr"},  ram_addr,       e.eaddr);
         chk({e.nm, ".ram_store"}, ram_store,      e.estore);
         if (e.eflg[4]) chk({e.nm, ".iload"}, iload, e.eiload);
         if (e.eflg[3]) chk({e.nm, ".dload"}, dload, e.edload);
      end

      // Contention: both ports requesting with a zero-wait memory must alternate D,I,D,I.
      @(posedge clk);
      #1;
      rst = 1'b0; halt = 1'b0; dwen = 1'b0;
      auto_mode = 1'b1; dren = 1'b1; iren = 1'b1;
      daddr = 32'h8000; iaddr = 32'h1000;
      for (int k = 0; k < 5; k++) begin
         h.is_d = 1'b1; h.data = 32'h8000 ^ MASK;
         sb.push_back(h);
         h.is_d = 1'b0; h.data = (32'h1000 + 32'(4 * k)) ^ MASK;
         sb.push_back(h);
      end
      nhits = 0;
      for (int cyc = 0; cyc < 30 && nhits < 10; cyc++) begin
         @(negedge clk);
         seen_i = ihit;
         chk("alt_exclusive", 32'(ihit & dhit), 32'd0);
         if (ihit || dhit) begin
            if (sb.size() == 0) begin
               chk("alt_unexpected_hit", 32'(nhits), 32'd10);
            end else begin
               h = sb.pop_front();
               chk("alt_port_is_d", 32'(dhit), 32'(h.is_d));
               chk("alt_data", dhit ? dload : iload, h.data);
            end
            nhits++;
         end
         @(posedge clk);
         #1;
         if (seen_i) iaddr = iaddr + 32'd4;
      end
      chk("alt_hit_count", 32'(nhits), 32'd10);
      chk("alt_sb_empty", 32'(sb.size()), 32'd0);

      // Reset out of a busy bus leaves everything quiet.
      auto_mode = 1'b0; dren = 1'b0; iren = 1'b0; rready_drv = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ren", 32'(ram_ren), 32'd0);
      chk("post_rst_hits", 32'({ihit, dhit, bus_err}), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
